// File: rtl/chan_fifo_ring.sv
// Ring storage behind the chan_fifo head register: DEPTH-1 entries with
// explicitly wrapped read/write pointers and an occupancy count.
module chan_fifo_ring #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    assign rdata = r_mem[r_rptr];
    assign empty = (r_count == '0);

    always_ff @(posedge clock) begin
        if (wen && !flush) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Non-power-of-two depths: wrap by compare, never by masking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (wen) begin
                r_wptr <= (r_wptr == PTR_W'(ENTRIES - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (ren) begin
                r_rptr <= (r_rptr == PTR_W'(ENTRIES - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({wen, ren})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/chan_fifo.sv
// Valid/ready FIFO channel: registered head word plus ring storage, with
// registered level, ready, valid and almost-full flags and synchronous flush.
module chan_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL       = DEPTH - 1,
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       idata,
    input  logic                   ivalid,
    output logic                   iready,
    output logic [WIDTH-1:0]       odata,
    output logic                   ovalid,
    input  logic                   oready,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   afull
);

    logic                   r_iready;
    logic                   r_ovalid;
    logic                   r_afull;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [WIDTH-1:0]       r_odata;

    logic                   w_itransfer;
    logic                   w_otransfer;
    logic                   w_head_load;
    logic                   w_direct;
    logic                   w_ring_wen;
    logic                   w_ring_ren;
    logic                   w_ring_empty;
    logic [WIDTH-1:0]       w_ring_rdata;
    logic [LEVEL_WIDTH-1:0] w_level_next;

    assign iready = r_iready;
    assign ovalid = r_ovalid;
    assign afull  = r_afull;
    assign level  = r_level;
    assign odata  = r_odata;

    // The head register refills whenever it empties or is consumed; an
    // incoming word bypasses the ring only when the ring has nothing older.
    always_comb begin
        w_itransfer  = ivalid && r_iready;
        w_otransfer  = r_ovalid && oready;
        w_head_load  = w_otransfer || !r_ovalid;
        w_ring_ren   = w_head_load && !w_ring_empty;
        w_direct     = w_head_load && w_ring_empty && w_itransfer;
        w_ring_wen   = w_itransfer && !w_direct;
        w_level_next = r_level - LEVEL_WIDTH'(w_otransfer) + LEVEL_WIDTH'(w_itransfer);
    end

    chan_fifo_ring #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 1)
    ) u_ring (
        .clock  (clock),
        .resetn (resetn),
        .flush  (flush),
        .wen    (w_ring_wen),
        .wdata  (idata),
        .ren    (w_ring_ren),
        .rdata  (w_ring_rdata),
        .empty  (w_ring_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_iready <= 1'b1;
            r_ovalid <= 1'b0;
            r_afull  <= 1'b0;
            r_level  <= '0;
        end else if (flush) begin
            r_iready <= 1'b1;
            r_ovalid <= 1'b0;
            r_afull  <= 1'b0;
            r_level  <= '0;
        end else begin
            r_iready <= (w_level_next != LEVEL_WIDTH'(DEPTH));
            r_ovalid <= (w_level_next != '0);
            r_afull  <= (w_level_next >= LEVEL_WIDTH'(AFULL));
            r_level  <= w_level_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!flush && w_head_load) begin
            if (!w_ring_empty) begin
                r_odata <= w_ring_rdata;
            end else if (w_itransfer) begin
                r_odata <= idata;
            end
        end
    end

endmodule

// File: tb/tb_chan_fifo.sv
// Bench for chan_fifo: queue-based reference models for a DEPTH=4 and a
// DEPTH=3 instance, checked every cycle, plus directed literal expectations.
module tb_chan_fifo;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic cmp_en = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Instance A: DEPTH=4, AFULL=3
    logic       a_flush = 1'b0, a_ivalid = 1'b0, a_oready = 1'b0;
    logic [7:0] a_idata = '0;
    logic       a_iready, a_ovalid, a_afull;
    logic [7:0] a_odata;
    logic [2:0] a_level;

    chan_fifo #(.WIDTH(8), .DEPTH(4)) u_a (
        .clock(clock), .resetn(resetn), .flush(a_flush),
        .idata(a_idata), .ivalid(a_ivalid), .iready(a_iready),
        .odata(a_odata), .ovalid(a_ovalid), .oready(a_oready),
        .level(a_level), .afull(a_afull)
    );

    // Instance B: DEPTH=3 (ring of 2), AFULL=2
    logic       b_flush = 1'b0, b_ivalid = 1'b0, b_oready = 1'b0;
    logic [7:0] b_idata = '0;
    logic       b_iready, b_ovalid, b_afull;
    logic [7:0] b_odata;
    logic [1:0] b_level;

    chan_fifo #(.WIDTH(8), .DEPTH(3)) u_b (
        .clock(clock), .resetn(resetn), .flush(b_flush),
        .idata(b_idata), .ivalid(b_ivalid), .iready(b_iready),
        .odata(b_odata), .ovalid(b_ovalid), .oready(b_oready),
        .level(b_level), .afull(b_afull)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference models: a queue of held words; transfers follow from the
    // queue size alone, flush empties it, reset empties it at once.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         ma_it, ma_ot, mb_it, mb_ot;
    int         b_pops = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            qa.delete();
        end else begin
            ma_it = a_ivalid && (qa.size() < 4);
            ma_ot = a_oready && (qa.size() > 0);
            if (a_flush) qa.delete();
            else begin
                if (ma_ot) void'(qa.pop_front());
                if (ma_it) qa.push_back(a_idata);
            end
        end
    end

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            qb.delete();
        end else begin
            mb_it = b_ivalid && (qb.size() < 3);
            mb_ot = b_oready && (qb.size() > 0);
            if (mb_ot) b_pops++;
            if (b_flush) qb.delete();
            else begin
                if (mb_ot) void'(qb.pop_front());
                if (mb_it) qb.push_back(b_idata);
            end
        end
    end

    // Words actually handed to A's consumer, for literal order checks.
    logic [7:0] a_out[$];
    always @(posedge clock) begin
        if (resetn && a_ovalid && a_oready) a_out.push_back(a_odata);
    end

    always @(negedge clock) begin
        if (cmp_en && resetn) begin
            check("a_level",  32'(a_level),  32'(qa.size()));
            check("a_ovalid", 32'(a_ovalid), 32'(qa.size() != 0));
            check("a_iready", 32'(a_iready), 32'(qa.size() != 4));
            check("a_afull",  32'(a_afull),  32'(qa.size() >= 3));
            if (qa.size() != 0) check("a_odata", 32'(a_odata), 32'(qa[0]));
            check("b_level",  32'(b_level),  32'(qb.size()));
            check("b_ovalid", 32'(b_ovalid), 32'(qb.size() != 0));
            check("b_iready", 32'(b_iready), 32'(qb.size() != 3));
            check("b_afull",  32'(b_afull),  32'(qb.size() >= 2));
            if (qb.size() != 0) check("b_odata", 32'(b_odata), 32'(qb[0]));
        end
    end

    logic [2:0] t1_level [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       t1_afull [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] t2_order [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    initial begin
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        cmp_en = 1'b1;
        @(negedge clock);
        check("rst_iready", 32'(a_iready), 32'd1);
        check("rst_ovalid", 32'(a_ovalid), 32'd0);
        check("rst_level",  32'(a_level),  32'd0);
        check("rst_afull",  32'(a_afull),  32'd0);

        // Fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            a_ivalid = 1'b1;
            a_idata  = 8'(8'h11 * (i + 1));
            @(negedge clock);
            check("t1_level", 32'(a_level), 32'(t1_level[i]));
            check("t1_afull", 32'(a_afull), 32'(t1_afull[i]));
        end
        check("t1_iready", 32'(a_iready), 32'd0);
        check("t1_odata",  32'(a_odata),  32'h11);

        // Drain from full while writing: no bubbles on the output
        a_out.delete();
        for (int k = 0; k < 6; k++) begin
            check("t2_ovalid", 32'(a_ovalid), 32'd1);
            if (k >= 1) check("t2_iready", 32'(a_iready), 32'd1);
            a_oready = 1'b1;
            a_ivalid = (k <= 2);
            a_idata  = (k <= 1) ? 8'h55 : 8'h66;
            @(negedge clock);
        end
        a_ivalid = 1'b0;
        a_oready = 1'b0;
        check("t2_count", 32'(a_out.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < a_out.size()) check("t2_order", 32'(a_out[k]), 32'(t2_order[k]));
        end
        check("t2_level_end", 32'(a_level), 32'd0);

        // Random traffic on the DEPTH=3 instance
        for (int n = 0; n < 1000; n++) begin
            b_ivalid = 1'($urandom_range(0, 1));
            b_oready = 1'($urandom_range(0, 1));
            b_idata  = 8'($urandom);
            @(negedge clock);
        end
        b_ivalid = 1'b0;
        b_oready = 1'b1;
        repeat (4) @(negedge clock);
        b_oready = 1'b0;
        check("t3_level_end", 32'(b_level), 32'd0);
        check("t3_traffic", 32'(b_pops > 100), 32'd1);

        // Single word through an empty FIFO
        a_out.delete();
        a_ivalid = 1'b1;
        a_idata  = 8'hA5;
        a_oready = 1'b1;
        @(negedge clock);
        a_ivalid = 1'b0;
        check("t4_ovalid", 32'(a_ovalid), 32'd1);
        check("t4_odata",  32'(a_odata),  32'hA5);
        check("t4_level",  32'(a_level),  32'd1);
        @(negedge clock);
        a_oready = 1'b0;
        check("t4_ovalid_after", 32'(a_ovalid), 32'd0);
        check("t4_level_after",  32'(a_level),  32'd0);
        check("t4_popped", 32'(a_out.size() == 1 && a_out[0] == 8'hA5), 32'd1);

        // Flush at level 3 with a simultaneous write and pop
        for (int i = 0; i < 3; i++) begin
            a_ivalid = 1'b1;
            a_idata  = 8'(i + 1);
            @(negedge clock);
        end
        check("t5_level_pre", 32'(a_level), 32'd3);
        a_flush  = 1'b1;
        a_idata  = 8'h77;
        a_oready = 1'b1;
        @(negedge clock);
        a_flush  = 1'b0;
        a_ivalid = 1'b0;
        check("t5_level",  32'(a_level),  32'd0);
        check("t5_ovalid", 32'(a_ovalid), 32'd0);
        check("t5_iready", 32'(a_iready), 32'd1);
        check("t5_afull",  32'(a_afull),  32'd0);
        repeat (3) @(negedge clock);
        check("t5_no77", 32'(a_ovalid), 32'd0);
        a_oready = 1'b0;

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 2; i++) begin
            a_ivalid = 1'b1;
            a_idata  = 8'(8'h10 * (i + 1));
            @(negedge clock);
        end
        check("t6_level_pre", 32'(a_level), 32'd2);
        a_idata = 8'h30;
        #1 resetn = 1'b0;
        a_ivalid = 1'b0;
        #1;
        check("t6_iready", 32'(a_iready), 32'd1);
        check("t6_ovalid", 32'(a_ovalid), 32'd0);
        check("t6_level",  32'(a_level),  32'd0);
        #1 resetn = 1'b1;
        @(negedge clock);
        a_out.delete();
        a_ivalid = 1'b1;
        a_idata  = 8'h01;
        a_oready = 1'b1;
        @(negedge clock);
        a_ivalid = 1'b0;
        check("t6_first_odata", 32'(a_odata), 32'h01);
        @(negedge clock);
        a_oready = 1'b0;
        check("t6_first_count", 32'(a_out.size()), 32'd1);
        if (a_out.size() > 0) check("t6_first_word", 32'(a_out[0]), 32'h01);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
